// File: rtl/popcount_enum_pkg.sv
// Shared types and defaults for the popcount enumerator.
// Optional feature macro: POPCOUNT_ENUM_COUNT_EN (match counter).
package popcount_enum_pkg;

  localparam int unsigned W_DEFAULT  = 8;
  localparam int unsigned KW_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/popcount_enum_popcount8.sv
// Combinational 8-bit population count built as a balanced adder tree.
module popcount8 (
  input  logic [7:0] in_word,
  output logic [3:0] count
);

  logic [1:0] pair_sum [4];
  logic [2:0] quad_sum [2];

  // Sum bit pairs, then pairs of pairs, then the two halves.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      pair_sum[i] = {1'b0, in_word[2*i]} + {1'b0, in_word[2*i+1]};
    end
    for (int unsigned j = 0; j < 2; j++) begin
      quad_sum[j] = {1'b0, pair_sum[2*j]} + {1'b0, pair_sum[2*j+1]};
    end
    count = {1'b0, quad_sum[0]} + {1'b0, quad_sum[1]};
  end

endmodule

// File: rtl/popcount_enum.sv
// Enumerates, in ascending order, every W-bit word whose popcount equals k.
// Optional feature macro: POPCOUNT_ENUM_COUNT_EN enables the match_count
// register; without it match_count is tied to zero.
module popcount_enum
  import popcount_enum_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned KW = KW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k,
  output logic          busy,
  output logic [W-1:0]  out_word,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          done,
  output logic [W-1:0]  match_count
);

  state_e        state_q, state_d;
  logic [W-1:0]  cand_q, cand_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  out_word_q, out_word_d;
  logic          out_valid_q, out_valid_d;
  logic          cnt_clr, cnt_inc;
  logic [3:0]    pc_cnt;
  logic          pc_match;
  logic [W-1:0]  last_mask;

  popcount8 u_popcount8 (
    .in_word (8'(cand_q)),
    .count   (pc_cnt)
  );

  assign pc_match = (32'(pc_cnt) == 32'(k_q));

  // Final word of a run has the top k bits set; k=0 gives an all-zero mask.
  always_comb begin
    last_mask = '0;
    for (int unsigned i = 0; i < W; i++) begin
      last_mask[W-1-i] = (i < 32'(k_q));
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && (out_word_q == last_mask);

  // Next-state and datapath updates for the enumeration FSM.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    k_d         = k_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k;
          cand_d  = '0;
          cnt_clr = 1'b1;
          state_d = (32'(k) > W) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (pc_match) begin
          out_word_d  = cand_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (cand_q == '1) begin
          state_d = DONE;
        end else begin
          cand_d = cand_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_inc     = 1'b1;
          if (out_last) begin
            state_d = DONE;
          end else begin
            cand_d  = cand_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      k_q         <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      k_q         <= k_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef POPCOUNT_ENUM_COUNT_EN
  logic [W-1:0] match_count_q, match_count_d;

  // Count handshakes; cleared on an accepted start.
  always_comb begin
    match_count_d = match_count_q;
    if (cnt_clr) begin
      match_count_d = '0;
    end else if (cnt_inc) begin
      match_count_d = match_count_q + 1'b1;
    end
  end

  // Match counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_count_q <= '0;
    end else begin
      match_count_q <= match_count_d;
    end
  end

  assign match_count = match_count_q;
`else
  logic unused_cnt;
  assign unused_cnt  = cnt_clr ^ cnt_inc;
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_popcount_enum.sv
// Self-checking bench for popcount_enum: directed scenarios plus randomized
// ready/start/k stimulus checked against a queue of expected words.
module tb_popcount_enum;

`ifdef POPCOUNT_ENUM_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] k;
  logic       busy;
  logic [7:0] out_word;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       done;
  logic [7:0] match_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  popcount_enum #(.W(8), .KW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .k           (k),
    .busy        (busy),
    .out_word    (out_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .done        (done),
    .match_count (match_count)
  );

  function automatic logic [31:0] exp_mc(input int n);
    return COUNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a run with target kk and follow it to its done pulse.
  task automatic run_stream(input int kk, input bit rand_ready, input bit poke_start);
    logic [7:0] expq[$];
    int         idx = 0;
    int         cyc = 0;
    int         done_seen = 0;
    bit         stalled = 1'b0;
    logic [7:0] held = '0;
    for (int v = 0; v < 256; v++) begin
      if ($countones(v) == kk) expq.push_back(8'(v));
    end
    @(negedge clk);
    start = 1'b1; k = 4'(kk); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done_seen == 0 && cyc < 3000) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      k         = 4'($urandom);
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_word", 32'(out_word), 32'(held));
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          chk("word", 32'(out_word), (idx < expq.size()) ? 32'(expq[idx]) : 32'hFFFF);
          chk("last", 32'(out_last), 32'(idx == expq.size() - 1));
          idx++;
        end else begin
          stalled = 1'b1;
          held    = out_word;
        end
      end
      if (done) done_seen++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; out_ready = 1'b1;
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("word_count", 32'(idx), 32'(expq.size()));
    chk("done_pulse_len", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("match_count", 32'(match_count), exp_mc(expq.size()));
  endtask

  initial begin
    int nv;
    int nd;
    rst = 1'b1; start = 1'b0; k = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_word", 32'(out_word), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mc", 32'(match_count), 32'd0);

    // Reset wins over start
    start = 1'b1; k = 4'd3;
    @(negedge clk);
    chk("rst_prio_busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    // k=0 timing: word at cycle 2, done at cycle 3, idle at cycle 4
    start = 1'b1; k = 4'd0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("k0_c1_busy", 32'(busy), 32'd1);
    chk("k0_c1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("k0_c2_valid", 32'(out_valid), 32'd1);
    chk("k0_c2_word", 32'(out_word), 32'h00);
    chk("k0_c2_last", 32'(out_last), 32'd1);
    @(negedge clk);
    chk("k0_c3_done", 32'(done), 32'd1);
    chk("k0_c3_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("k0_c4_busy", 32'(busy), 32'd0);
    chk("k0_c4_done", 32'(done), 32'd0);
    chk("k0_mc", 32'(match_count), exp_mc(1));

    run_stream(8, 1'b0, 1'b0);
    run_stream(2, 1'b0, 1'b0);
    run_stream(4, 1'b1, 1'b0);

    // k>W: straight to done, no words
    @(negedge clk);
    start = 1'b1; k = 4'd9;
    nv = 0; nd = 0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) nv++;
      if (done) nd++;
      @(negedge clk);
    end
    chk("k9_valid_cnt", 32'(nv), 32'd0);
    chk("k9_done_cnt", 32'(nd), 32'd1);
    chk("k9_busy", 32'(busy), 32'd0);
    chk("k9_mc", 32'(match_count), 32'd0);

    run_stream(3, 1'b1, 1'b1);

    // Reset while holding the third k=3 word
    @(negedge clk);
    start = 1'b1; k = 4'd3; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nv = 0;
    while (!(out_valid && out_word == 8'h0D) && nv < 200) begin
      @(negedge clk);
      nv++;
    end
    chk("hold_reached", 32'(out_word), 32'h0D);
    out_ready = 1'b0;
    @(negedge clk);
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_mc", 32'(match_count), exp_mc(2));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mc", 32'(match_count), 32'd0);
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(nd), 32'd0);

    run_stream(3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
